// File: rtl/e_mdu_pkg.sv
// Shared opcodes, default latencies, FSM state type and arithmetic helper for the E-stage MDU.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    localparam int MDU_CNT_W       = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // wr=0 marks a result that must not reach HI/LO (divide by zero).
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    function automatic logic is_compute(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic mdu_res_t mdu_compute(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        mdu_res_t    r;
        logic [63:0] prod;
        r    = '0;
        prod = '0;
        case (op)
            MDU_MULT: begin
                prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r    = '{wr: 1'b1, hi: prod[63:32], lo: prod[31:0]};
            end
            MDU_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                r    = '{wr: 1'b1, hi: prod[63:32], lo: prod[31:0]};
            end
            MDU_DIV: begin
                // INT_MIN / -1 overflows the quotient; pin it rather than trust the operator.
                if (b == 32'd0)
                    r.wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = '{wr: 1'b1, hi: 32'd0, lo: 32'h8000_0000};
                else
                    r = '{wr: 1'b1, hi: $signed(a) % $signed(b), lo: $signed(a) / $signed(b)};
            end
            MDU_DIVU: begin
                if (b == 32'd0)
                    r.wr = 1'b0;
                else
                    r = '{wr: 1'b1, hi: a % b, lo: a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO. Define MDU_DELAY_EN for the multi-cycle
// busy window; otherwise compute ops commit at the accepting edge and busy stays 0.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  MDUcon,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDUout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    mdu_res_t    res;

    assign start = is_compute(MDUcon);
    assign res   = mdu_compute(MDUcon, in1, in2);
    assign HI    = hi_q;
    assign LO    = lo_q;

    always_comb begin
        case (MDUcon)
            MDU_MFHI: MDUout = hi_q;
            MDU_MFLO: MDUout = lo_q;
            default:  MDUout = 32'd0;
        endcase
    end

`ifdef MDU_DELAY_EN
    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    mdu_res_t             pend_q, pend_d;

    assign busy = (state_q == ST_RUN);

    always_comb begin
        // NOTE: every target gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pend_d  = res;
                    cnt_d   = ((MDUcon == MDU_MULT) || (MDUcon == MDU_MULTU))
                              ? MDU_CNT_W'(MULT_CYCLES) : MDU_CNT_W'(DIV_CYCLES);
                    state_d = ST_RUN;
                end else if (MDUcon == MDU_MTHI) begin
                    hi_d = in1;
                end else if (MDUcon == MDU_MTLO) begin
                    lo_d = in1;
                end
            end
            ST_RUN: begin
                // Compute and move ops are dropped here; the hazard unit keeps them away.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= MDU_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (pend_q.wr) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments only; next-state math stays in always_comb.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (start) begin
            if (res.wr) begin
                hi_d = res.hi;
                lo_d = res.lo;
            end
        end else if (MDUcon == MDU_MTHI) begin
            hi_d = in1;
        end else if (MDUcon == MDU_MTLO) begin
            lo_d = in1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
`endif

endmodule

// File: tb/tb_e_mdu.sv
// Directed, table-driven bench for e_mdu; follows MDU_DELAY_EN the same way the RTL does.
module tb_e_mdu;
    import e_mdu_pkg::*;

`ifdef MDU_DELAY_EN
    localparam int MC = 5;
    localparam int DC = 10;
`else
    localparam int MC = 0;
    localparam int DC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in1, in2;
    logic [3:0]  MDUcon;
    logic        start, busy;
    logic [31:0] MDUout, HI, LO;

    int total = 0;
    int bad   = 0;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .in1    (in1),
        .in2    (in2),
        .MDUcon (MDUcon),
        .start  (start),
        .busy   (busy),
        .MDUout (MDUout),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] out;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cycles(input logic [3:0] op);
        if (op == MDU_MULT || op == MDU_MULTU) return MC;
        if (op == MDU_DIV || op == MDU_DIVU)   return DC;
        return 0;
    endfunction

    // Present one op for a single cycle, then wait out any busy window with a bound.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_out);
        int n;
        logic exp_start;
        exp_start = (op >= 4'd1 && op <= 4'd4);
        MDUcon = op; in1 = a; in2 = b;
        #1;
        check({name, " start"}, {31'd0, start}, {31'd0, exp_start});
        check({name, " mduout"}, MDUout, exp_out);
        tick();
        MDUcon = MDU_NONE; in1 = '0; in2 = '0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({name, " busy_cycles"}, n, exp_cycles(op));
    endtask

    initial begin
        vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0};
        vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 32'd0};
        vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0};
        vecs[3]  = '{MDU_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         32'd0};
        vecs[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 32'd0};
        vecs[5]  = '{MDU_MULT,  32'd3,         32'd4,         32'd0,         32'd12,        32'd0};
        vecs[6]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 32'd0};
        vecs[7]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'd0};
        vecs[8]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         32'd0};
        vecs[9]  = '{MDU_MTHI,  32'h11,        32'd0,         32'h11,        32'd0,         32'd0};
        vecs[10] = '{MDU_MTLO,  32'h22,        32'd0,         32'h11,        32'h22,        32'd0};
        vecs[11] = '{MDU_DIV,   32'd5,         32'd0,         32'h11,        32'h22,        32'd0};
        vecs[12] = '{MDU_DIVU,  32'd5,         32'd0,         32'h11,        32'h22,        32'd0};
        vecs[13] = '{MDU_MFHI,  32'd0,         32'd0,         32'h11,        32'h22,        32'h11};
        vecs[14] = '{MDU_MFLO,  32'd0,         32'd0,         32'h11,        32'h22,        32'h22};
        vecs[15] = '{4'd9,      32'hDEAD_BEEF, 32'd1,         32'h11,        32'h22,        32'd0};
        vecs[16] = '{MDU_MTHI,  32'h1234,      32'd0,         32'h1234,      32'h22,        32'd0};
        vecs[17] = '{MDU_MFHI,  32'd0,         32'd0,         32'h1234,      32'h22,        32'h1234};
        vecs[18] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, 32'd0};
        vecs[19] = '{MDU_MFLO,  32'd0,         32'd0,         32'd15,        32'h0FFF_FFFF, 32'h0FFF_FFFF};

        reset = 1'b1; MDUcon = MDU_NONE; in1 = '0; in2 = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        check("reset mduout", MDUout, 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out);
            check($sformatf("vec%0d hi", i), HI, vecs[i].hi);
            check($sformatf("vec%0d lo", i), LO, vecs[i].lo);
        end

`ifdef MDU_DELAY_EN
        // mtlo while busy is dropped; LO ends up with the mult result.
        MDUcon = MDU_MULT; in1 = 32'd3; in2 = 32'd4;
        tick();
        check("mtlo_busy busy", {31'd0, busy}, 32'd1);
        MDUcon = MDU_MTLO; in1 = 32'h99;
        tick();
        MDUcon = MDU_NONE;
        for (int i = 0; i < 10; i++) tick();
        check("mtlo_busy lo", LO, 32'd12);

        // Second mult presented while busy is ignored; window length unchanged.
        begin
            int n;
            MDUcon = MDU_MULT; in1 = 32'd3; in2 = 32'd5;
            tick();
            MDUcon = MDU_MULT; in1 = 32'd6; in2 = 32'd7;
            check("b2b hi_unchanged", HI, 32'd0);
            n = 0;
            while (busy === 1'b1 && n < 100) begin
                n++;
                tick();
                MDUcon = MDU_NONE;
            end
            check("b2b busy_cycles", n, 32'd5);
            check("b2b lo", LO, 32'd15);
        end

        // Reset in the fourth busy cycle of a div cancels it.
        MDUcon = MDU_MTHI; in1 = 32'h77; tick();
        MDUcon = MDU_DIVU; in1 = 32'd100; in2 = 32'd7; tick();
        MDUcon = MDU_NONE;
        tick(); tick(); tick();
        check("rst_mid busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        check("rst_mid hi", HI, 32'd0);
        check("rst_mid lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("rst_mid no_commit hi", HI, 32'd0);
        check("rst_mid no_commit lo", LO, 32'd0);
`else
        // Consecutive mults each commit at their own edge; busy never rises.
        MDUcon = MDU_MULT; in1 = 32'd3; in2 = 32'd4; tick();
        check("nodelay lo1", LO, 32'd12);
        check("nodelay busy1", {31'd0, busy}, 32'd0);
        MDUcon = MDU_MULT; in1 = 32'd5; in2 = 32'd6; tick();
        check("nodelay lo2", LO, 32'd30);
        check("nodelay busy2", {31'd0, busy}, 32'd0);
        MDUcon = MDU_NONE;

        MDUcon = MDU_MTHI; in1 = 32'h55; tick();
        MDUcon = MDU_NONE;
        check("rst_pre hi", HI, 32'h55);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst hi", HI, 32'd0);
        check("rst lo", LO, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
